// File: rtl/rtc_pkg.sv
// Shared constants, types and helpers for the RTC segment decoder
// and alarm controller.
package rtc_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_RING   = 2'd2,
      ST_SNOOZE = 2'd3
   } state_e;

   typedef struct packed {
      logic [3:0] h_m;
      logic [3:0] h_l;
      logic [3:0] m_m;
      logic [3:0] m_l;
   } hhmm_t;

   function automatic logic hhmm_ok(hhmm_t t);
      return (t.h_m <= 4'd2) && (t.h_l <= 4'd9) &&
             (t.h_m != 4'd2 || t.h_l <= 4'd3) &&
             (t.m_m <= 4'd5) && (t.m_l <= 4'd9);
   endfunction

   // Operand is always a validated hh:mm, so one wrap subtraction suffices.
   function automatic hhmm_t bcd_add_min(hhmm_t t, logic [5:0] add);
      logic [10:0] tot;
      logic [4:0]  hh;
      logic [5:0]  mm;
      hhmm_t       r;
      tot = 11'(t.h_m) * 11'd600 + 11'(t.h_l) * 11'd60 +
            11'(t.m_m) * 11'd10 + 11'(t.m_l) + 11'(add);
      if (tot >= 11'd1440) tot = tot - 11'd1440;
      hh = 5'(tot / 11'd60);
      mm = 6'(tot % 11'd60);
      r.h_m = 4'(hh / 5'd10);
      r.h_l = 4'(hh % 5'd10);
      r.m_m = 4'(mm / 6'd10);
      r.m_l = 4'(mm % 6'd10);
      return r;
   endfunction

endpackage

// File: rtl/rtc_seg2bcd.sv
// Single-digit active-low seven-segment to BCD decoder.
// Unknown patterns decode to 4'hF with vld_o low.
module rtc_seg2bcd
   import rtc_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] bcd_o,
   output logic       vld_o
);

   always_comb begin
      bcd_o = 4'hF;
      vld_o = 1'b1;
      case (seg_i)
         SEG_0:   bcd_o = 4'd0;
         SEG_1:   bcd_o = 4'd1;
         SEG_2:   bcd_o = 4'd2;
         SEG_3:   bcd_o = 4'd3;
         SEG_4:   bcd_o = 4'd4;
         SEG_5:   bcd_o = 4'd5;
         SEG_6:   bcd_o = 4'd6;
         SEG_7:   bcd_o = 4'd7;
         SEG_8:   bcd_o = 4'd8;
         SEG_9:   bcd_o = 4'd9;
         default: vld_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/rtc_seg_alarm.sv
// Segment-to-BCD time recovery with seconds tick and an hh:mm alarm
// supporting acknowledge, snooze and ring timeout.
module rtc_seg_alarm
   import rtc_pkg::*;
#(
   parameter int unsigned SNOOZE_MIN = 5,
   parameter int unsigned RING_SECS  = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  HR_M,
   input  logic [6:0]  HR_L,
   input  logic [6:0]  MIN_M,
   input  logic [6:0]  MIN_L,
   input  logic [6:0]  SEC_M,
   input  logic [6:0]  SEC_L,
   input  logic        alarm_en,
   input  logic        alarm_set,
   input  logic [15:0] alarm_hhmm,
   output logic        alarm_rdy,
   output logic        set_err,
   input  logic        ack,
   input  logic        snooze,
   output logic [23:0] time_bcd,
   output logic        time_valid,
   output logic        sec_tick,
   output logic        alarm_ring,
   output logic [1:0]  state
);

   logic [6:0]  seg_q [6];
   logic [3:0]  dig [6];
   logic [5:0]  dv;
   logic [23:0] dec_bcd;
   logic        dec_valid;
   logic [23:0] time_q;
   logic        valid_q, tick_q;

   state_e      state_q, state_d;
   hhmm_t       alarm_q, alarm_d, tgt_q, tgt_d, base, now_hm;
   logic        loaded_q, loaded_d, tgt_set_q, tgt_set_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        rdy_q, err_q;
   logic        set_ok, set_good, hit;

   for (genvar g = 0; g < 6; g++) begin : g_dec
      rtc_seg2bcd u_dec (
         .seg_i (seg_q[g]),
         .bcd_o (dig[g]),
         .vld_o (dv[g])
      );
   end

   assign dec_bcd   = {dig[0], dig[1], dig[2], dig[3], dig[4], dig[5]};
   assign dec_valid = (&dv) && (dig[0] <= 4'd2) &&
                      (dig[0] != 4'd2 || dig[1] <= 4'd3) &&
                      (dig[2] <= 4'd5) && (dig[4] <= 4'd5);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 6; i++) seg_q[i] <= SEG_BLANK;
         time_q  <= '0;
         valid_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         seg_q[0] <= HR_M;
         seg_q[1] <= HR_L;
         seg_q[2] <= MIN_M;
         seg_q[3] <= MIN_L;
         seg_q[4] <= SEC_M;
         seg_q[5] <= SEC_L;
         time_q   <= dec_bcd;
         valid_q  <= dec_valid;
         // A tick needs two consecutive valid samples.
         tick_q   <= dec_valid && valid_q &&
                     (dec_bcd[7:0] != time_q[7:0]);
      end
   end

   assign set_ok   = alarm_set && rdy_q;
   assign set_good = hhmm_ok(hhmm_t'(alarm_hhmm));
   assign now_hm   = hhmm_t'(time_q[23:8]);
   assign hit      = tick_q && valid_q && (time_q[7:0] == 8'h00);
   assign base     = tgt_set_q ? tgt_q : alarm_q;

   always_comb begin
      state_d   = state_q;
      alarm_d   = alarm_q;
      loaded_d  = loaded_q;
      tgt_d     = tgt_q;
      tgt_set_d = tgt_set_q;
      cnt_d     = cnt_q;
      if (set_ok && set_good) begin
         alarm_d   = hhmm_t'(alarm_hhmm);
         loaded_d  = 1'b1;
         tgt_d     = '0;
         tgt_set_d = 1'b0;
      end
      if (!alarm_en) begin
         state_d   = ST_IDLE;
         tgt_d     = '0;
         tgt_set_d = 1'b0;
         cnt_d     = '0;
      end else begin
         unique case (state_q)
            ST_IDLE:
               if (loaded_d) state_d = ST_ARMED;
            ST_ARMED:
               if (hit && now_hm == alarm_q) state_d = ST_RING;
            ST_RING:
               if (ack) begin
                  state_d = ST_ARMED;
                  cnt_d   = '0;
               end else if (snooze) begin
                  state_d   = ST_SNOOZE;
                  tgt_d     = bcd_add_min(base, 6'(SNOOZE_MIN));
                  tgt_set_d = 1'b1;
                  cnt_d     = '0;
               end else if (tick_q) begin
                  if (cnt_q == 8'(RING_SECS - 1)) begin
                     state_d = ST_ARMED;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            ST_SNOOZE:
               if (ack) state_d = ST_ARMED;
               else if (hit && now_hm == tgt_q) state_d = ST_RING;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         alarm_q   <= '0;
         loaded_q  <= 1'b0;
         tgt_q     <= '0;
         tgt_set_q <= 1'b0;
         cnt_q     <= '0;
         rdy_q     <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         alarm_q   <= alarm_d;
         loaded_q  <= loaded_d;
         tgt_q     <= tgt_d;
         tgt_set_q <= tgt_set_d;
         cnt_q     <= cnt_d;
         rdy_q     <= (state_d == ST_IDLE) || (state_d == ST_ARMED);
         err_q     <= set_ok && !set_good;
      end
   end

   assign time_bcd   = time_q;
   assign time_valid = valid_q;
   assign sec_tick   = tick_q;
   assign alarm_rdy  = rdy_q;
   assign set_err    = err_q;
   assign alarm_ring = (state_q == ST_RING);
   assign state      = state_q;

endmodule

// File: tb/tb_rtc_seg_alarm.sv
// Bench for rtc_seg_alarm: directed alarm scenarios plus random
// time/pulse stimulus against a minute-of-day reference model.
module tb_rtc_seg_alarm;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [6:0]  hr_m = 7'h7F, hr_l = 7'h7F, min_m = 7'h7F;
   logic [6:0]  min_l = 7'h7F, sec_m = 7'h7F, sec_l = 7'h7F;
   logic        alarm_en = 1'b0, alarm_set = 1'b0;
   logic        ack = 1'b0, snooze = 1'b0;
   logic [15:0] alarm_hhmm = '0;
   logic        alarm_rdy, set_err, time_valid, sec_tick, alarm_ring;
   logic [23:0] time_bcd;
   logic [1:0]  state;

   always #5 clk = ~clk;

   rtc_seg_alarm dut (
      .clk        (clk),
      .rst        (rst),
      .HR_M       (hr_m),
      .HR_L       (hr_l),
      .MIN_M      (min_m),
      .MIN_L      (min_l),
      .SEC_M      (sec_m),
      .SEC_L      (sec_l),
      .alarm_en   (alarm_en),
      .alarm_set  (alarm_set),
      .alarm_hhmm (alarm_hhmm),
      .alarm_rdy  (alarm_rdy),
      .set_err    (set_err),
      .ack        (ack),
      .snooze     (snooze),
      .time_bcd   (time_bcd),
      .time_valid (time_valid),
      .sec_tick   (sec_tick),
      .alarm_ring (alarm_ring),
      .state      (state)
   );

   logic [6:0] seg_tab [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

   int n_pass = 0;
   int n_total = 0;
   bit cmp_en = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int dec(input logic [6:0] s);
      for (int i = 0; i < 10; i++) if (s == seg_tab[i]) return i;
      return 15;
   endfunction

   function automatic bit hhmm_good(input logic [15:0] v);
      int h, m;
      h = int'(v[15:12]) * 10 + int'(v[11:8]);
      m = int'(v[7:4]) * 10 + int'(v[3:0]);
      return v[15:12] < 10 && v[11:8] < 10 && v[7:4] < 10 &&
             v[3:0] < 10 && h < 24 && m < 60;
   endfunction

   function automatic int hhmm_min(input logic [15:0] v);
      return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 +
             int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [15:0] to_hhmm(input int mins);
      int h, m;
      h = mins / 60;
      m = mins % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   // Reference model: pipeline of decoded digits plus alarm behaviour
   // expressed in minutes-of-day.
   int          d1 [6] = '{15, 15, 15, 15, 15, 15};
   logic [23:0] m_time = '0;
   bit          m_valid = 0, m_tick = 0;
   int          m_ss = 0, m_hm = 0;
   int          m_st = 0, m_alarm = 0, m_tgt = 0, m_cnt = 0;
   bit          m_loaded = 0, m_tgt_set = 0, m_rdy = 1, m_serr = 0;

   task automatic model_reset();
      for (int i = 0; i < 6; i++) d1[i] = 15;
      m_time = '0; m_valid = 0; m_tick = 0; m_ss = 0; m_hm = 0;
      m_st = 0; m_alarm = 0; m_tgt = 0; m_cnt = 0;
      m_loaded = 0; m_tgt_set = 0; m_rdy = 1; m_serr = 0;
   endtask

   task automatic model_step();
      bit acc, okv, hit, nv, ok_dig;
      int old_alarm, ns, hh, mm, ss;
      hit = m_tick && m_valid && m_ss == 0;
      acc = alarm_set && m_rdy;
      okv = hhmm_good(alarm_hhmm);
      old_alarm = m_alarm;
      m_serr = acc && !okv;
      if (acc && okv) begin
         m_alarm = hhmm_min(alarm_hhmm);
         m_loaded = 1;
         m_tgt_set = 0;
      end
      ns = m_st;
      if (!alarm_en) begin
         ns = 0; m_tgt_set = 0; m_cnt = 0;
      end else if (m_st == 0) begin
         if (m_loaded) ns = 1;
      end else if (m_st == 1) begin
         if (hit && m_hm == old_alarm) ns = 2;
      end else if (m_st == 2) begin
         if (ack) begin
            ns = 1; m_cnt = 0;
         end else if (snooze) begin
            m_tgt = ((m_tgt_set ? m_tgt : old_alarm) + 5) % 1440;
            m_tgt_set = 1; ns = 3; m_cnt = 0;
         end else if (m_tick) begin
            m_cnt++;
            if (m_cnt == 60) begin ns = 1; m_cnt = 0; end
         end
      end else begin
         if (ack) ns = 1;
         else if (hit && m_tgt_set && m_hm == m_tgt) ns = 2;
      end
      m_st = ns;
      m_rdy = (ns < 2);
      ok_dig = 1;
      for (int i = 0; i < 6; i++) if (d1[i] > 9) ok_dig = 0;
      hh = d1[0] * 10 + d1[1];
      mm = d1[2] * 10 + d1[3];
      ss = d1[4] * 10 + d1[5];
      nv = ok_dig && hh < 24 && mm < 60 && ss < 60;
      m_tick = nv && m_valid && ss != m_ss;
      m_valid = nv;
      m_ss = ss;
      m_hm = hh * 60 + mm;
      m_time = {4'(d1[0]), 4'(d1[1]), 4'(d1[2]), 4'(d1[3]),
                4'(d1[4]), 4'(d1[5])};
      d1[0] = dec(hr_m);  d1[1] = dec(hr_l);
      d1[2] = dec(min_m); d1[3] = dec(min_l);
      d1[4] = dec(sec_m); d1[5] = dec(sec_l);
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      if (rst && cmp_en) begin
         chk("time_bcd", time_bcd, m_time);
         chk("time_valid", time_valid, m_valid);
         chk("sec_tick", sec_tick, m_tick);
         chk("state", state, m_st);
         chk("alarm_ring", alarm_ring, m_st == 2);
         chk("alarm_rdy", alarm_rdy, m_rdy);
         chk("set_err", set_err, m_serr);
      end
   end

   task automatic drive_t(input int t);
      int hh, mm, ss;
      hh = t / 3600;
      mm = (t / 60) % 60;
      ss = t % 60;
      hr_m  = seg_tab[hh / 10]; hr_l  = seg_tab[hh % 10];
      min_m = seg_tab[mm / 10]; min_l = seg_tab[mm % 10];
      sec_m = seg_tab[ss / 10]; sec_l = seg_tab[ss % 10];
   endtask

   task automatic hold(input int t, input int n);
      drive_t(t);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic pulse(input logic a, input logic s, input logic st,
                        input logic [15:0] v);
      ack = a; snooze = s; alarm_set = st; alarm_hhmm = v;
      @(negedge clk); #1;
      ack = 0; snooze = 0; alarm_set = 0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_time"}, time_bcd, 24'h0);
      chk({tag, "_valid"}, time_valid, 0);
      chk({tag, "_tick"}, sec_tick, 0);
      chk({tag, "_err"}, set_err, 0);
      chk({tag, "_ring"}, alarm_ring, 0);
      chk({tag, "_state"}, state, 0);
      chk({tag, "_rdy"}, alarm_rdy, 1);
   endtask

   function automatic int hms(input int h, input int m, input int s);
      return h * 3600 + m * 60 + s;
   endfunction

   initial begin
      int ticks, r, t, k;
      bit saw_zero;
      repeat (2) begin @(negedge clk); #1; end
      chk_reset_vals("rst");
      rst = 1;
      cmp_en = 1;

      ticks = 0;
      saw_zero = 0;
      for (int s = 86397; s < 86402; s++) begin
         drive_t(s % 86400);
         repeat (2) begin
            @(negedge clk); #1;
            if (sec_tick) ticks++;
            if (time_valid && time_bcd == 24'h0) saw_zero = 1;
         end
      end
      repeat (2) begin
         @(negedge clk); #1;
         if (sec_tick) ticks++;
      end
      chk("wrap_ticks", ticks, 4);
      chk("wrap_zero_seen", saw_zero, 1);
      chk("wrap_final", time_bcd, 24'h000001);

      drive_t(2);
      sec_l = 7'h7F;
      @(negedge clk); #1;
      drive_t(3);
      @(negedge clk); #1;
      chk("glitch_valid", time_valid, 0);
      chk("glitch_sl", time_bcd[3:0], 4'hF);
      @(negedge clk); #1;
      chk("glitch_recover_valid", time_valid, 1);
      chk("glitch_no_tick", sec_tick, 0);

      alarm_en = 1;
      pulse(0, 0, 1, 16'h0730);
      chk("set0730_state", state, 1);
      hold(hms(7, 29, 59), 2);
      hold(hms(7, 30, 0), 2);
      chk("ring_tick", sec_tick, 1);
      chk("ring_pre_state", state, 1);
      hold(hms(7, 30, 0), 1);
      chk("ring_state", state, 2);
      chk("ring_out", alarm_ring, 1);
      pulse(1, 0, 0, 16'h0);
      chk("ack_state", state, 1);

      pulse(0, 0, 1, 16'h2358);
      hold(hms(23, 57, 59), 2);
      hold(hms(23, 58, 0), 3);
      chk("ring2358", state, 2);
      pulse(0, 1, 0, 16'h0);
      chk("snooze1_state", state, 3);
      chk("snooze1_tgt", m_tgt, 3);
      hold(hms(0, 2, 59), 2);
      hold(hms(0, 3, 0), 3);
      chk("ring0003", state, 2);
      pulse(0, 1, 0, 16'h0);
      chk("snooze2_tgt", m_tgt, 8);
      hold(hms(0, 7, 59), 2);
      hold(hms(0, 8, 0), 3);
      chk("ring0008", state, 2);

      t = hms(0, 8, 0);
      for (int i = 1; i <= 60; i++) hold(t + i, 1);
      hold(t + 60, 1);
      chk("timeout_pre", state, 2);
      hold(t + 60, 1);
      chk("timeout_state", state, 1);
      chk("timeout_ring", alarm_ring, 0);

      hold(hms(23, 57, 59), 2);
      hold(hms(23, 58, 0), 3);
      chk("ring_again", state, 2);
      pulse(1, 1, 0, 16'h0);
      chk("ack_snooze_state", state, 1);

      pulse(0, 0, 1, 16'h2400);
      chk("bad_set_err", set_err, 1);
      chk("bad_set_state", state, 1);
      @(negedge clk); #1;
      chk("bad_set_err_clr", set_err, 0);

      hold(hms(23, 57, 59), 2);
      hold(hms(23, 58, 0), 3);
      pulse(0, 0, 1, 16'h1200);
      chk("set_in_ring_err", set_err, 0);
      chk("set_in_ring_state", state, 2);
      chk("set_in_ring_alarm", m_alarm, 1438);

      #2 rst = 0;
      #1 chk_reset_vals("midring");
      @(negedge clk); #1;
      rst = 1;

      t = $urandom_range(0, 86399);
      for (int c = 0; c < 3000; c++) begin
         r = $urandom_range(0, 99);
         if (r < 60) t = (t + 1) % 86400;
         else if (r < 66)
            t = ((($urandom_range(0, 1) == 1 && m_tgt_set) ? m_tgt : m_alarm)
                 * 60 - $urandom_range(1, 3) + 86400) % 86400;
         drive_t(t);
         if (r >= 92) begin
            k = $urandom_range(0, 5);
            case (k)
               0: hr_m  = 7'($urandom);
               1: hr_l  = 7'($urandom);
               2: min_m = 7'($urandom);
               3: min_l = 7'($urandom);
               4: sec_m = 7'($urandom);
               default: sec_l = 7'($urandom);
            endcase
         end
         ack = ($urandom_range(0, 99) < 3);
         snooze = ($urandom_range(0, 99) < 5);
         alarm_set = ($urandom_range(0, 99) < 3);
         alarm_hhmm = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                  : to_hhmm($urandom_range(0, 1439));
         if ($urandom_range(0, 199) == 0) alarm_en = ~alarm_en;
         else if (!alarm_en && $urandom_range(0, 19) == 0) alarm_en = 1;
         @(negedge clk); #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rtc_seg_alarm.md
# rtc_seg_alarm

Decoder and alarm controller on the consumer side of the real-time clock's seven-segment outputs. It converts the six active-low segment buses back into BCD, checks each digit and the time as a whole for validity, and produces a one-cycle tick whenever the seconds change. It also runs a programmable hh:mm alarm with acknowledge, snooze and a ring timeout. It sits beside the display, fed directly by the clock block in the same clock domain.

## Interface
- SNOOZE_MIN, 5: snooze offset in minutes, range 1..59.
- RING_SECS, 60: seconds of unacknowledged ringing before auto-return to ARMED, range 1..255.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset), synchronous deassert handled upstream.
- HR_M, HR_L, MIN_M, MIN_L, SEC_M, SEC_L  in  7 each  active-low segments {a,b,c,d,e,f,g}.
- alarm_en  in  1  level; 0 forces IDLE.
- alarm_set  in  1  pulse; load alarm_hhmm.
- alarm_hhmm  in  16  BCD {h_m,h_l,m_m,m_l}.
- alarm_rdy  out  1  high in IDLE and ARMED only.
- set_err  out  1  one-cycle pulse when an accepted alarm_set carries an out-of-range value.
- ack, snooze  in  1 each  pulses, meaningful in RING/SNOOZE.
- time_bcd  out  24  {h_m,h_l,m_m,m_l,s_m,s_l}.
- time_valid  out  1  all six digits decode and the time is in range.
- sec_tick  out  1  one-cycle pulse on a seconds change.
- alarm_ring  out  1  high while in RING.
- state  out  2  IDLE=0, ARMED=1, RING=2, SNOOZE=3.

## Operation
- Segment codes: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Any other pattern, including blank 1111111, makes that digit invalid; its BCD field reads 4'hF.
- Range rules for time_valid: h_m≤2; h_l≤3 when h_m=2; m_m≤5; s_m≤5; every digit decodes.
- sec_tick fires when time_valid=1 and {s_m,s_l} differs from the previous registered value, and that previous value was also valid.
  - The first valid sample after reset or after an invalid period gives no tick.
- Alarm set is accepted when alarm_set=1 and alarm_rdy=1.
  - Valid value (hh≤23, mm≤59, BCD digits): load the alarm register, clear the snooze target.
  - Invalid value: pulse set_err; register and state unchanged.
  - alarm_set while alarm_rdy=0 is ignored silently.
- FSM, with priority rst > alarm_en=0 > the rest:
  - IDLE→ARMED: valid set accepted while alarm_en=1.
  - ARMED→RING: sec_tick, time_valid=1, time = alarm:00.
  - RING→ARMED: ack, or RING_SECS sec_ticks counted without ack.
  - RING→SNOOZE: snooze. Target = previous target + SNOOZE_MIN in BCD, wrapping at 24:00 (23:58+5 → 00:03). Previous target = snooze target if set, else the alarm register. Repeated snoozes accumulate.
  - SNOOZE→RING: sec_tick with time = target:00.
  - SNOOZE→ARMED: ack.
  - ack and snooze in the same cycle: ack wins.
  - Any state→IDLE: alarm_en=0. Alarm register retained; snooze target and ring counter cleared.
  - IDLE→ARMED on alarm_en rising, provided the alarm register has been loaded since reset.
- While time_valid=0, no match is possible and the ring counter holds.

## Timing
- Reset values:
  - time_bcd=0, time_valid=0, sec_tick=0, set_err=0, alarm_ring=0.
  - state=IDLE, alarm_rdy=1.
  - Alarm register 0, loaded flag 0, snooze target cleared, ring counter 0.
- Two-stage pipeline: segment inputs are registered at edge N; time_bcd, time_valid and sec_tick update at edge N+1.
- State and alarm_ring change at the edge after the qualifying sec_tick, ack or snooze cycle.
- alarm_rdy and set_err are registered; set_err is asserted the cycle after the set.
- Ring timeout: the RING_SECS-th sec_tick in RING causes exit at the following edge.
- Reset mid-RING: outputs return to reset values asynchronously.

## Structure
- Package rtc_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK constants.
  - The 2-bit state encoding.
  - A BCD hh:mm struct/type.
  - The BCD add-minutes-with-wrap function.
- Sub-module rtc_seg2bcd: combinational single-digit decoder (7-bit in → 4-bit BCD + valid), instantiated six times.

## Test plan
- Feed the clock from 23:59:58 through 00:00:01 → time_bcd follows two cycles late; four sec_ticks with wrap to 00:00:00.
- Set SEC_L=1111111 for one sample → time_valid=0, s_l=F; no sec_tick on the next valid sample.
- alarm_set 07:30 with alarm_en=1, time reaches 07:30:00 → state RING, alarm_ring=1 one cycle after the tick; ack → ARMED.
- In RING, snooze twice, alarm 23:58 → targets 00:03 then 00:08; RING again at 00:03:00.
- Ring with no ack for 60 ticks → ARMED exactly on the 60th tick+1; ack and snooze pulsed together → ARMED.
- alarm_set 24:00 → set_err pulse, state unchanged; alarm_set during RING → ignored; rst low during RING → all outputs at reset values immediately.
